lcd_msg_streamer: RTL and testbench

Parametrised successor to the fixed two-message LCD text generator on the conveyor line. Holds a table of N_MSG status messages of COLS characters each. Whenever the selected message changes or a refresh is requested, it streams that message one character per handshake to the downstream LCD write driver. The driver sits between the production-line controller, which supplies `msg_sel`, and the LCD character interface.

---
 rtl/lcd_msg_pkg.sv | 38 +++
 rtl/lcd_msg_rom.sv | 20 ++
 rtl/lcd_msg_streamer.sv | 135 +++++++++++++
 tb/tb_lcd_msg_streamer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_msg_pkg.sv
// Shared types, message indices and the LCD message text table.
package lcd_msg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MSG_CARREGANDO  = 0;
   localparam int MSG_CAIXA_CHEIA = 1;
   localparam int MSG_PARADA      = 2;
   localparam int MSG_ERRO        = 3;

   localparam logic [7:0] CH_SPACE = 8'h20;

   // widest text slot in the table; strings are stored right-justified
   localparam int MSG_MAX_LEN = 16;

   // Character at column col of message idx; blanks past the text end and
   // for indices with no text.
   function automatic logic [7:0] msg_char(input int unsigned idx, input int unsigned col);
      logic [8*MSG_MAX_LEN-1:0] txt;
      int unsigned              len;
      txt = '0;
      len = 0;
      case (idx)
         0: begin txt = {{(MSG_MAX_LEN-11)*8{1'b0}}, "CARREGANDO!"};    len = 11; end
         1: begin txt = {{(MSG_MAX_LEN-12)*8{1'b0}}, "CAIXA CHEIA!"};   len = 12; end
         2: begin txt = {{(MSG_MAX_LEN-14)*8{1'b0}}, "ESTEIRA PARADA"}; len = 14; end
         3: begin txt = {{(MSG_MAX_LEN-11)*8{1'b0}}, "ERRO SENSOR"};    len = 11; end
         default: begin txt = '0; len = 0; end
      endcase
      if (col < len) msg_char = txt[8*(len-1-col) +: 8];
      else           msg_char = CH_SPACE;
   endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Combinational message table lookup: (sel, col) -> ASCII character.
// Selections beyond N_MSG read as blanks.
module lcd_msg_rom import lcd_msg_pkg::*; #(
   parameter int COLS  = 16,
   parameter int N_MSG = 4,
   parameter int SW    = $clog2(N_MSG),
   parameter int CW    = $clog2(COLS)
) (
   input  logic [SW-1:0] sel,
   input  logic [CW-1:0] col,
   output logic [7:0]    ch
);

   // table read with out-of-range selection forced to blank
   always_comb begin
      ch = CH_SPACE;
      if (32'(sel) < 32'(N_MSG)) ch = msg_char(32'(sel), 32'(col));
   end

endmodule

// File: rtl/lcd_msg_streamer.sv
// Streams one COLS-character status message to the LCD write driver
// whenever the selection changes or a refresh is requested.
// Optional build macro LCD_MSG_BLINK_EN: blink message 1 by alternating
// text and blank streams every BLINK_CYC idle cycles.
module lcd_msg_streamer import lcd_msg_pkg::*; #(
   parameter  int COLS      = 16,
   parameter  int N_MSG     = 4,
   parameter  int BLINK_CYC = 25_000_000,
   localparam int SW        = $clog2(N_MSG),
   localparam int CW        = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [SW-1:0] msg_sel,
   input  logic          refresh,
   output logic [7:0]    ch_data,
   output logic [CW-1:0] ch_col,
   output logic          ch_valid,
   input  logic          ch_ready,
   output logic          busy,
   output logic          done
);

   state_t        state, state_nxt;
   logic [SW-1:0] sel_q;
   logic [CW-1:0] col_q;
   logic          pend;
   logic          start;
   logic          accept;
   logic          last_col;
   logic          blink_pend;
   logic          blank_ph;
   logic [7:0]    rom_ch;

   // a new stream is launched only from IDLE; intermediate msg_sel values
   // seen during SEND/DONE are simply never latched
   assign start    = (state == IDLE) && (pend || (msg_sel != sel_q));
   assign accept   = (state == SEND) && ch_ready;
   assign last_col = (col_q == CW'(COLS-1));

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state and Moore outputs (outputs depend on state only)
   always_comb begin
      state_nxt = state;
      ch_valid  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: if (start) state_nxt = SEND;
         SEND: begin
            ch_valid = 1'b1;
            busy     = 1'b1;
            if (ch_ready && last_col) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // selection latch, column counter and resend request flag; a refresh
   // coinciding with a launch is absorbed by that launch
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= '0;
         col_q <= '0;
         pend  <= 1'b1;
      end else begin
         if (start) begin
            sel_q <= msg_sel;
            col_q <= '0;
         end else if (accept && !last_col) begin
            col_q <= col_q + CW'(1);
         end
         if (start)                      pend <= 1'b0;
         else if (refresh || blink_pend) pend <= 1'b1;
      end
   end

`ifdef LCD_MSG_BLINK_EN
   localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

   logic [BW-1:0] blink_cnt;
   logic          blink_run;

   // counter only advances in IDLE cycles that do not launch a stream, so a
   // wrap can never be swallowed by a launch clearing pend
   assign blink_run  = (state == IDLE) && !start && (sel_q == SW'(MSG_CAIXA_CHEIA));
   assign blink_pend = blink_run && (blink_cnt == BW'(BLINK_CYC-1));

   // blink phase counter; leaving message 1 returns to the visible phase
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blank_ph  <= 1'b0;
      end else if (start && (msg_sel != SW'(MSG_CAIXA_CHEIA))) begin
         blink_cnt <= '0;
         blank_ph  <= 1'b0;
      end else if (blink_run) begin
         if (blink_pend) begin
            blink_cnt <= '0;
            blank_ph  <= ~blank_ph;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end
`else
   // BLINK_CYC has no effect in this build
   logic unused_blink;
   assign unused_blink = ^BLINK_CYC;
   assign blink_pend   = 1'b0;
   assign blank_ph     = 1'b0;
`endif

   lcd_msg_rom #(
      .COLS  (COLS),
      .N_MSG (N_MSG)
   ) u_rom (
      .sel (sel_q),
      .col (col_q),
      .ch  (rom_ch)
   );

   assign ch_data = blank_ph ? CH_SPACE : rom_ch;
   assign ch_col  = col_q;

endmodule

// File: tb/tb_lcd_msg_streamer.sv
// Self-checking bench for lcd_msg_streamer: table-driven start-up and
// selection-change vectors, hand sequences for stalls/toggles/refresh/reset,
// and a randomized phase checked against a string-table reference model.
module tb_lcd_msg_streamer;

   localparam int COLS = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] msg_sel = 2'd0;
   logic       refresh = 1'b0;
   logic [7:0] ch_data;
   logic [3:0] ch_col;
   logic       ch_valid;
   logic       ch_ready = 1'b1;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   lcd_msg_streamer #(.COLS(COLS), .N_MSG(4), .BLINK_CYC(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .msg_sel  (msg_sel),
      .refresh  (refresh),
      .ch_data  (ch_data),
      .ch_col   (ch_col),
      .ch_valid (ch_valid),
      .ch_ready (ch_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic string msg_str(input int s);
      case (s)
         0: return "CARREGANDO!";
         1: return "CAIXA CHEIA!";
         2: return "ESTEIRA PARADA";
         3: return "ERRO SENSOR";
         default: return "";
      endcase
   endfunction

   function automatic logic [7:0] exp_char(input int s, input int c);
      string m;
      m = msg_str(s);
      if (c < m.len()) return m[c];
      return 8'h20;
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   // ---------------- stream monitor ----------------
   logic       content_en = 1'b1;
   int         streams = 0;
   int         last_sel = -1;
   int         last_len = 0;
   logic [7:0] cur_buf  [COLS];
   logic [7:0] last_buf [COLS];
   logic       in_stream = 1'b0;
   logic       want_done = 1'b0;
   int         idx = 0;
   int         cur_sel = 0;
   int         start_n = 0;
   int         ncnt = 0;
   int         sel_prev = 0;

   always @(negedge clk) begin
      ncnt++;
      if (rst) begin
         in_stream = 1'b0;
         want_done = 1'b0;
      end else begin
         if (want_done) begin
            checks++;
            if (!(done === 1'b1 && ch_valid === 1'b0)) begin
               errors++;
               $display("FAIL done_after_last: got done=%b valid=%b, want done=1 valid=0", done, ch_valid);
            end
            want_done = 1'b0;
            streams++;
            last_len = ncnt - start_n;
            last_buf = cur_buf;
         end else if (done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got done=%b, want 0", done);
         end
         if (ch_valid === 1'b1) begin
            if (!in_stream) begin
               in_stream = 1'b1;
               cur_sel   = sel_prev;
               last_sel  = sel_prev;
               idx       = 0;
               start_n   = ncnt;
            end
            checks++;
            if (ch_col !== 4'(idx) || busy !== 1'b1 ||
                (content_en && ch_data !== exp_char(cur_sel, idx))) begin
               errors++;
               $display("FAIL stream_char: msg %0d got col=%0d data=%h busy=%b, want col=%0d data=%h busy=1",
                        cur_sel, ch_col, ch_data, busy, idx, exp_char(cur_sel, idx));
            end
            cur_buf[idx] = ch_data;
            if (ch_ready) begin
               idx++;
               if (idx == COLS) begin
                  in_stream = 1'b0;
                  want_done = 1'b1;
               end
            end
         end
      end
      sel_prev = int'(msg_sel);
   end

   // ---------------- vector tables ----------------
   typedef struct {
      logic       valid;
      logic       done;
      logic [3:0] col;
      logic [7:0] data;
   } vec_t;

   vec_t vq[$];

   // cycle-by-cycle picture of one stream: idle, 16 chars, done, idle
   task automatic build_vecs(input logic [127:0] hexs);
      vq.delete();
      vq.push_back('{valid: 1'b0, done: 1'b0, col: 4'd0, data: 8'h00});
      for (int i = 0; i < COLS; i++)
         vq.push_back('{valid: 1'b1, done: 1'b0, col: 4'(i), data: hexs[8*(15-i) +: 8]});
      vq.push_back('{valid: 1'b0, done: 1'b1, col: 4'd0, data: 8'h00});
      vq.push_back('{valid: 1'b0, done: 1'b0, col: 4'd0, data: 8'h00});
   endtask

   task automatic run_vecs(input string nm);
      foreach (vq[i]) begin
         @(negedge clk);
         checks++;
         if (ch_valid !== vq[i].valid || done !== vq[i].done ||
             (vq[i].valid && (ch_col !== vq[i].col || ch_data !== vq[i].data))) begin
            errors++;
            $display("FAIL %s[%0d]: got valid=%b done=%b col=%0d data=%h, want valid=%b done=%b col=%0d data=%h",
                     nm, i, ch_valid, done, ch_col, ch_data,
                     vq[i].valid, vq[i].done, vq[i].col, vq[i].data);
         end
      end
   endtask

   task automatic settle(input string nm);
      int quiet;
      quiet = 0;
      for (int i = 0; i < 300 && quiet < 4; i++) begin
         @(negedge clk);
         if (!busy && !done) quiet++;
         else                quiet = 0;
      end
      chk({nm, "_settle"}, int'(quiet >= 4), 1);
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_stream(input string nm);
      int s0;
      s0 = streams;
      for (int i = 0; i < 200 && streams == s0; i++) @(negedge clk);
      chk({nm, "_stream_seen"}, int'(streams != s0), 1);
   endtask

   // ---------------- stimulus ----------------
   logic [127:0] h0, h1;
   int           s0;
   logic         found;

   initial begin
      h0 = {8'h43, 8'h41, 8'h52, 8'h52, 8'h45, 8'h47, 8'h41, 8'h4E,
            8'h44, 8'h4F, 8'h21, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
      h1 = {8'h43, 8'h41, 8'h49, 8'h58, 8'h41, 8'h20, 8'h43, 8'h48,
            8'h45, 8'h49, 8'h41, 8'h21, 8'h20, 8'h20, 8'h20, 8'h20};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", int'(ch_valid), 0);
      chk("reset_busy",  int'(busy), 0);
      chk("reset_done",  int'(done), 0);

      // automatic message 0 after reset release
      drive_edge();
      rst = 1'b0;
      build_vecs(h0);
      run_vecs("boot_msg0");

`ifndef LCD_MSG_BLINK_EN
      // selection change in IDLE launches on the next cycle
      drive_edge();
      msg_sel = 2'd1;
      build_vecs(h1);
      run_vecs("sel_0to1");

      // three-cycle stall at column 5
      s0 = streams;
      drive_edge();
      refresh = 1'b1;
      drive_edge();
      refresh = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         drive_edge();
         if (ch_valid && ch_col == 4'd5) found = 1'b1;
      end
      chk("stall_reach_col5", int'(found), 1);
      ch_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_col",  int'(ch_col), 5);
         chk("stall_data", int'(ch_data), 32'h20);
         drive_edge();
      end
      ch_ready = 1'b1;
      settle("stall");
      chk("stall_streams", streams, s0 + 1);
      chk("stall_len", last_len, COLS + 3);

      // selection toggles during SEND: only the final value follows
      drive_edge();
      msg_sel = 2'd0;
      settle("pre_toggle");
      chk("plain_len", last_len, COLS);
      s0 = streams;
      drive_edge();
      msg_sel = 2'd1;
      repeat (3) drive_edge();
      msg_sel = 2'd2;
      repeat (2) drive_edge();
      msg_sel = 2'd3;
      settle("toggle");
      chk("toggle_streams", streams, s0 + 2);
      chk("toggle_last_sel", last_sel, 3);

      // refresh together with a change gives exactly one stream
      s0 = streams;
      drive_edge();
      msg_sel = 2'd0;
      refresh = 1'b1;
      drive_edge();
      refresh = 1'b0;
      settle("refresh_change");
      chk("refresh_change_streams", streams, s0 + 1);
      chk("refresh_change_sel", last_sel, 0);
      repeat (40) @(negedge clk);
      chk("no_spurious_resend", streams, s0 + 1);

      // reset during SEND aborts without done, then message 0 restarts
      s0 = streams;
      drive_edge();
      refresh = 1'b1;
      drive_edge();
      refresh = 1'b0;
      repeat (5) drive_edge();
      chk("abort_in_send", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_valid", int'(ch_valid), 0);
      chk("abort_busy",  int'(busy), 0);
      chk("abort_done",  int'(done), 0);
      drive_edge();
      rst = 1'b0;
      settle("abort");
      chk("abort_streams", streams, s0 + 1);
      chk("abort_sel", last_sel, 0);

      // randomized traffic against the string-table model
      for (int i = 0; i < 1500; i++) begin
         drive_edge();
         ch_ready = ($urandom_range(3) != 0);
         if ($urandom_range(7) == 0) msg_sel = 2'($urandom_range(3));
         refresh = ($urandom_range(15) == 0);
      end
      drive_edge();
      refresh  = 1'b0;
      ch_ready = 1'b1;
      settle("random");
      chk("random_final_sel", last_sel, int'(msg_sel));
`else
      // blink: message 1 alternates visible and blank streams
      content_en = 1'b0;
      drive_edge();
      msg_sel = 2'd1;
      for (int k = 0; k < 5; k++) begin
         logic is_text, is_blank;
         wait_stream("blink");
         is_text  = 1'b1;
         is_blank = 1'b1;
         for (int c = 0; c < COLS; c++) begin
            if (last_buf[c] !== exp_char(1, c)) is_text  = 1'b0;
            if (last_buf[c] !== 8'h20)          is_blank = 1'b0;
         end
         chk("blink_kind", is_text ? 1 : (is_blank ? 2 : 0), (k % 2 == 0) ? 1 : 2);
         chk("blink_sel", last_sel, 1);
      end
      // leaving message 1 shows text 0 and stops blink resends
      drive_edge();
      msg_sel = 2'd0;
      found = 1'b0;
      for (int k = 0; k < 3 && !found; k++) begin
         logic ok;
         wait_stream("unblink");
         ok = (last_sel == 0);
         for (int c = 0; c < COLS; c++)
            if (last_buf[c] !== exp_char(0, c)) ok = 1'b0;
         if (ok) found = 1'b1;
      end
      chk("unblink_msg0_text", int'(found), 1);
      s0 = streams;
      repeat (60) @(negedge clk);
      chk("unblink_quiet", streams, s0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
